cal_seq_ctrl: RTL and testbench

CAL_SEQ_CTRL -- requirements
Module: cal_seq_ctrl

---
 rtl/cal_seq_ctrl_if.sv | 26 ++
 rtl/cal_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_cal_seq_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cal_seq_ctrl_if.sv
// Request/response bundle for the calculation sequencer: operation in, result out.
// Master is the requester/consumer side; slave is the sequencer.
interface cal_seq_ctrl_if #(
    parameter int unsigned W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   result;
    logic             flag;
    logic             err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flag, err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flag, err
    );
endinterface

// File: rtl/cal_seq_ctrl.sv
// Sequenced ADD/SUB/MUL unit: one-cycle add/sub, W-cycle shift-add multiply,
// valid/ready handshakes on both sides, results held until the next completion.
module cal_seq_ctrl #(
    parameter int unsigned W = 4
) (
    input  logic          clk,
    input  logic          rst,
    cal_seq_ctrl_if.slave bus
);
    localparam int unsigned RW = 2 * W;
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state,     state_nxt;
    logic [1:0]      op_q,      op_nxt;
    logic [W-1:0]    a_q,       a_nxt;
    logic [W-1:0]    b_q,       b_nxt;
    logic [RW-1:0]   mcand_q,   mcand_nxt;
    logic [RW-1:0]   acc_q,     acc_nxt;
    logic [CW-1:0]   cnt_q,     cnt_nxt;
    logic            in_ready_q,  in_ready_nxt;
    logic            out_valid_q, out_valid_nxt;
    logic [RW-1:0]   result_q,  result_nxt;
    logic            flag_q,    flag_nxt;
    logic            err_q,     err_nxt;

    logic [W:0]      sum;
    logic [W-1:0]    diff;
    logic [RW-1:0]   acc_add;

    // Datapath terms; b_q doubles as the right-shifting multiplier in MUL.
    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        diff    = a_q - b_q;
        acc_add = acc_q + (b_q[0] ? mcand_q : '0);
    end

    // Next-state and next-register values.
    always_comb begin
        state_nxt     = state;
        op_nxt        = op_q;
        a_nxt         = a_q;
        b_nxt         = b_q;
        mcand_nxt     = mcand_q;
        acc_nxt       = acc_q;
        cnt_nxt       = cnt_q;
        in_ready_nxt  = in_ready_q;
        out_valid_nxt = out_valid_q;
        result_nxt    = result_q;
        flag_nxt      = flag_q;
        err_nxt       = err_q;

        case (state)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    op_nxt       = bus.op;
                    a_nxt        = bus.a;
                    b_nxt        = bus.b;
                    mcand_nxt    = RW'(bus.a);
                    acc_nxt      = '0;
                    cnt_nxt      = '0;
                    in_ready_nxt = 1'b0;
                    state_nxt    = (bus.op == OP_MUL) ? MUL : EXEC;
                end
            end
            EXEC: begin
                case (op_q)
                    OP_ADD: begin
                        result_nxt = RW'(sum);
                        flag_nxt   = sum[W];
                        err_nxt    = 1'b0;
                    end
                    OP_SUB: begin
                        result_nxt = RW'(diff);
                        flag_nxt   = (a_q < b_q);
                        err_nxt    = 1'b0;
                    end
                    default: begin
                        result_nxt = '0;
                        flag_nxt   = 1'b0;
                        err_nxt    = 1'b1;
                    end
                endcase
                out_valid_nxt = 1'b1;
                state_nxt     = DONE;
            end
            MUL: begin
                acc_nxt   = acc_add;
                mcand_nxt = mcand_q << 1;
                b_nxt     = b_q >> 1;
                cnt_nxt   = cnt_q + CW'(1);
                // Last iteration: counter wraps and the final sum is published.
                if (cnt_q == CW'(W - 1)) begin
                    cnt_nxt       = '0;
                    result_nxt    = acc_add;
                    flag_nxt      = |acc_add[RW-1:W];
                    err_nxt       = 1'b0;
                    out_valid_nxt = 1'b1;
                    state_nxt     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_nxt = 1'b0;
                    in_ready_nxt  = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset overrides any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mcand_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flag_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_nxt;
            op_q        <= op_nxt;
            a_q         <= a_nxt;
            b_q         <= b_nxt;
            mcand_q     <= mcand_nxt;
            acc_q       <= acc_nxt;
            cnt_q       <= cnt_nxt;
            in_ready_q  <= in_ready_nxt;
            out_valid_q <= out_valid_nxt;
            result_q    <= result_nxt;
            flag_q      <= flag_nxt;
            err_q       <= err_nxt;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flag      = flag_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_cal_seq_ctrl.sv
// Bench for cal_seq_ctrl: directed vector table, hand-written handshake/reset
// sequences and random operations checked against an arithmetic model.
module tb_cal_seq_ctrl;
    localparam int unsigned W  = 4;
    localparam int unsigned RW = 2 * W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cal_seq_ctrl_if #(.W(W)) bus ();

    cal_seq_ctrl #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] op;
        int         a;
        int         b;
        int         res;
        bit         fl;
        bit         er;
        int         lat;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outcome from the arithmetic definition; lat is the index of the
    // first edge (accept edge = 0) that samples out_valid high.
    function automatic void model(input logic [1:0] op, input int a, input int b,
                                  output int res, output bit fl, output bit er,
                                  output int lat);
        int mod;
        mod = 1 << W;
        er  = 1'b0;
        lat = 2;
        case (op)
            2'd0: begin res = a + b;               fl = (a + b) >= mod; end
            2'd1: begin res = (a - b + mod) % mod; fl = (a < b);        end
            2'd2: begin res = a * b;               fl = (a * b) >= mod; lat = W + 1; end
            default: begin res = 0; fl = 1'b0; er = 1'b1; end
        endcase
    endfunction

    // Waits for the result of an already-accepted op, checks it, holds it for
    // 'hold' cycles with out_ready low, then completes the output handshake.
    task automatic finish_op(input string tag, input int exp_res, input bit exp_fl,
                             input bit exp_er, input int exp_lat, input int hold);
        int n;
        chk({tag, " in_ready busy"}, 32'(bus.in_ready), 32'd0);
        n = 1;
        while (!bus.out_valid && n < 30) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(exp_lat));
        chk({tag, " result"}, 32'(bus.result), 32'(exp_res));
        chk({tag, " flag"}, 32'(bus.flag), 32'(exp_fl));
        chk({tag, " err"}, 32'(bus.err), 32'(exp_er));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, " hold valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, " hold result"}, 32'(bus.result), 32'(exp_res));
            chk({tag, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
        chk({tag, " in_ready back"}, 32'(bus.in_ready), 32'd1);
        chk({tag, " result kept"}, 32'(bus.result), 32'(exp_res));
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input int a, input int b,
                          input int exp_res, input bit exp_fl, input bit exp_er,
                          input int exp_lat, input int hold);
        chk({tag, " in_ready idle"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = W'(a);
        bus.b        = W'(b);
        tick();
        // Scramble operands after accept; the block must not resample them.
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        finish_op(tag, exp_res, exp_fl, exp_er, exp_lat, hold);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, l, seen;
        bit f, e;
        logic [1:0] rop;
        int ra, rb;

        tbl[0] = '{2'd0,  9,  8, 8'h11, 1'b1, 1'b0, 2};
        tbl[1] = '{2'd1,  3,  5, 8'h0E, 1'b1, 1'b0, 2};
        tbl[2] = '{2'd1,  7,  7, 8'h00, 1'b0, 1'b0, 2};
        tbl[3] = '{2'd2, 15, 15, 8'hE1, 1'b1, 1'b0, 5};
        tbl[4] = '{2'd2,  3,  4, 8'h0C, 1'b0, 1'b0, 5};
        tbl[5] = '{2'd3,  5,  5, 8'h00, 1'b0, 1'b1, 2};
        tbl[6] = '{2'd0,  1,  1, 8'h02, 1'b0, 1'b0, 2};
        tbl[7] = '{2'd0, 15, 15, 8'h1E, 1'b1, 1'b0, 2};
        tbl[8] = '{2'd2,  0,  9, 8'h00, 1'b0, 1'b0, 5};
        tbl[9] = '{2'd1, 15,  0, 8'h0F, 1'b0, 1'b0, 2};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = 2'd0;
        bus.a         = '0;
        bus.b         = '0;
        rst           = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset result", 32'(bus.result), 32'd0);
        chk("reset flag", 32'(bus.flag), 32'd0);
        chk("reset err", 32'(bus.err), 32'd0);

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                   tbl[i].res, tbl[i].fl, tbl[i].er, tbl[i].lat, i % 2);

        // MUL 2*3 stalled by the consumer while a new ADD 1+1 waits on in_valid.
        bus.in_valid = 1'b1;
        bus.op = 2'd2; bus.a = W'(2); bus.b = W'(3);
        tick();
        bus.op = 2'd0; bus.a = W'(1); bus.b = W'(1);
        finish_op("stall mul", 8'h06, 1'b0, 1'b0, 5, 3);
        tick();
        chk("stall next accepted", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        finish_op("stall next add", 8'h02, 1'b0, 1'b0, 2, 0);

        // Put a nonzero result in place, then reset during the second MUL iteration.
        run_op("pre reset", 2'd0, 9, 8, 8'h11, 1'b1, 1'b0, 2, 0);
        bus.in_valid = 1'b1;
        bus.op = 2'd2; bus.a = W'(15); bus.b = W'(15);
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst result", 32'(bus.result), 32'd0);
        chk("midrst flag", 32'(bus.flag), 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        chk("midrst no result", 32'(seen), 32'd0);
        run_op("post reset add", 2'd0, 1, 1, 8'h02, 1'b0, 1'b0, 2, 0);

        // Reset wins over a simultaneous output handshake and a new request.
        bus.in_valid = 1'b1;
        bus.op = 2'd2; bus.a = W'(3); bus.b = W'(4);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10 && !bus.out_valid; i++) tick();
        chk("prio result before", 32'(bus.result), 32'h0C);
        rst = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        tick();
        rst = 1'b0; bus.out_ready = 1'b0; bus.in_valid = 1'b0;
        chk("prio out_valid", 32'(bus.out_valid), 32'd0);
        chk("prio in_ready", 32'(bus.in_ready), 32'd1);
        chk("prio result", 32'(bus.result), 32'd0);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = int'($urandom_range(0, (1 << W) - 1));
            rb  = int'($urandom_range(0, (1 << W) - 1));
            model(rop, ra, rb, r, f, e, l);
            run_op($sformatf("rnd%0d op%0d %0d,%0d", i, rop, ra, rb), rop, ra, rb,
                   r, f, e, l, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
